// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Multi-cycle fetch/PC controller: fetches over a req/ack
//               handshake, waits for execution, then commits PC+4/branch/jump.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'h00400020,
    parameter int unsigned FETCH_TIMEOUT = 16,
    parameter int unsigned TMO_W         = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        ex_done,
    input  logic        br_taken,
    input  logic [15:0] br_imm16,
    input  logic        jmp_valid,
    input  logic [25:0] jmp_target,
    input  logic        halt,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [1:0]  state,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_EXEC   = 2'd2,
        S_UPDATE = 2'd3
    } state_t;

    localparam bit             c_tmo_en   = (FETCH_TIMEOUT != 0);
    localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(FETCH_TIMEOUT - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_pc;
    logic [31:0]        r_next_pc;
    logic [31:0]        r_instr;
    logic               r_instr_valid;
    logic               r_fetch_err;
    logic [TMO_W-1:0]   r_cnt;

    logic [31:0]        w_pc_plus4;
    logic [31:0]        w_br_off;
    logic [31:0]        w_target;
    logic               w_timeout;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_br_off   = {{14{br_imm16[15]}}, br_imm16, 2'b00};
    assign w_timeout  = c_tmo_en && (r_cnt == c_tmo_last);

    // Jump outranks a taken branch when both are flagged together.
    always_comb begin
        w_target = w_pc_plus4;
        if (jmp_valid) begin
            w_target = {w_pc_plus4[31:28], jmp_target, 2'b00};
        end else if (br_taken) begin
            w_target = w_pc_plus4 + w_br_off;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!halt && !r_fetch_err) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack)       w_state_nxt = S_EXEC;
                else if (w_timeout) w_state_nxt = S_IDLE;
            end
            S_EXEC: begin
                if (ex_done) w_state_nxt = S_UPDATE;
            end
            S_UPDATE: begin
                w_state_nxt = halt ? S_IDLE : S_FETCH;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_next_pc     <= RESET_PC;
            r_instr       <= 32'd0;
            r_instr_valid <= 1'b0;
            r_fetch_err   <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_instr_valid <= (r_state == S_FETCH) && imem_ack;
            case (r_state)
                S_FETCH: begin
                    // An ack coinciding with the timeout cycle is accepted, not flagged.
                    if (imem_ack) begin
                        r_instr <= imem_rdata;
                        r_cnt   <= '0;
                    end else if (w_timeout) begin
                        r_fetch_err <= 1'b1;
                        r_cnt       <= '0;
                    end else begin
                        r_cnt <= r_cnt + TMO_W'(1);
                    end
                end
                S_EXEC: begin
                    if (ex_done) r_next_pc <= w_target;
                end
                S_UPDATE: begin
                    r_pc <= r_next_pc;
                end
                default: ;
            endcase
        end
    end

    assign imem_req    = (r_state == S_FETCH);
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign state       = r_state;
    assign fetch_err   = r_fetch_err;

endmodule
`default_nettype wire
